// File: rtl/gridding_pkg.sv
// Shared types and sizing for the gridding back end.
// GRID_ACCUM_SATURATE_EN selects saturating instead of wrapping grid accumulation.
package gridding_pkg;

  localparam int unsigned PRECISION = 32;
  localparam int unsigned KFRAC     = 30;
  localparam int unsigned GSIZE     = 32;
  localparam int unsigned ADDR_W    = 16;

  typedef struct packed {
    logic signed [PRECISION-1:0] re;
    logic signed [PRECISION-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StClear
  } state_t;

`ifdef GRID_ACCUM_SATURATE_EN
  localparam logic signed [PRECISION-1:0] SatMax = {1'b0, {(PRECISION-1){1'b1}}};
  localparam logic signed [PRECISION-1:0] SatMin = {1'b1, {(PRECISION-1){1'b0}}};

  // One extra bit of headroom exposes signed overflow as a sign/carry disagreement.
  function automatic logic signed [PRECISION-1:0] sat_add(
    input  logic signed [PRECISION-1:0] a,
    input  logic signed [PRECISION-1:0] b,
    output logic                        ovf
  );
    logic signed [PRECISION:0] w;
    w   = {a[PRECISION-1], a} + {b[PRECISION-1], b};
    ovf = w[PRECISION] ^ w[PRECISION-1];
    if (!ovf) begin
      return w[PRECISION-1:0];
    end else if (w[PRECISION]) begin
      return SatMin;
    end else begin
      return SatMax;
    end
  endfunction
`else
  function automatic cplx_t add_wrap(input cplx_t a, input cplx_t b);
    cplx_t s;
    s.re = a.re + b.re;
    s.im = a.im + b.im;
    return s;
  endfunction
`endif

endpackage

// File: rtl/cmul_q.sv
// Registered complex multiplier: p = (a * b) >>> KFRAC, truncated to PRECISION bits.
module cmul_q import gridding_pkg::*; (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  cplx_t a,
  input  cplx_t b,
  output cplx_t p
);

  localparam int unsigned PW = 2 * PRECISION + 1;

  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [PRECISION-1:0] pr, pi;

  always_comb begin
    rr = PW'(a.re) * PW'(b.re);
    ii = PW'(a.im) * PW'(b.im);
    ri = PW'(a.re) * PW'(b.im);
    ir = PW'(a.im) * PW'(b.re);
    pr = PRECISION'((rr - ii) >>> KFRAC);
    pi = PRECISION'((ri + ir) >>> KFRAC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= '0;
    end else if (en) begin
      p.re <= pr;
      p.im <= pi;
    end
  end

endmodule

// File: rtl/grid_accum.sv
// Gridding read-modify-write accumulator with in-flight forwarding and grid clearing.
// GRID_ACCUM_SATURATE_EN: saturating accumulation plus sticky sat_flag output.
module grid_accum import gridding_pkg::*; (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [ADDR_W-1:0]           gind,
  input  logic [ADDR_W-1:0]           cind,
  input  logic signed [PRECISION-1:0] indatar,
  input  logic signed [PRECISION-1:0] indatai,
  input  logic                        clear,
  output logic                        busy,
  output logic                        drop_err,
`ifdef GRID_ACCUM_SATURATE_EN
  output logic                        sat_flag,
`endif
  output logic [ADDR_W-1:0]           conv_addr,
  input  logic signed [PRECISION-1:0] conv_datar,
  input  logic signed [PRECISION-1:0] conv_datai,
  output logic [ADDR_W-1:0]           grid_raddr,
  input  logic signed [PRECISION-1:0] grid_rdatar,
  input  logic signed [PRECISION-1:0] grid_rdatai,
  output logic                        grid_we,
  output logic [ADDR_W-1:0]           grid_waddr,
  output logic signed [PRECISION-1:0] grid_wdatar,
  output logic signed [PRECISION-1:0] grid_wdatai
);

  localparam int unsigned       NCells   = GSIZE * GSIZE;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NCells - 1);

  state_t            state_q;
  logic              v1_q, v2_q, hit1_q;
  logic [ADDR_W-1:0] g1_q, g2_q, clr_cnt_q;
  cplx_t             d1_q, hold1_q, base2_q;
  cplx_t             kern, rdat, wdat, prod2, base1, base, sum;
  logic              accept, clr_go;
`ifdef GRID_ACCUM_SATURATE_EN
  logic              ovf_re, ovf_im;
`endif

  assign conv_addr  = cind;
  assign grid_raddr = gind;

  assign kern = '{re: conv_datar, im: conv_datai};
  assign rdat = '{re: grid_rdatar, im: grid_rdatai};
  assign wdat = '{re: grid_wdatar, im: grid_wdatai};

  assign accept = valid && (state_q != StClear);
  // Zeroing waits for every accepted sample to reach the write port first.
  assign clr_go = (state_q == StClear) && !v1_q && !v2_q && !clear;
  assign busy   = (state_q == StClear) || v1_q || v2_q || grid_we;

  cmul_q u_cmul (
    .clk (clk),
    .rst (rst),
    .en  (v1_q),
    .a   (d1_q),
    .b   (kern),
    .p   (prod2)
  );

  // The write register is snooped at every stage: at stage 0 it holds the write the memory
  // read misses (read-first), at stage 1 the next one, at stage 2 the youngest older sum.
  always_comb begin
    base1 = rdat;
    if (grid_we && (grid_waddr == g1_q)) begin
      base1 = wdat;
    end else if (hit1_q) begin
      base1 = hold1_q;
    end
    base = base2_q;
    if (grid_we && (grid_waddr == g2_q)) begin
      base = wdat;
    end
`ifdef GRID_ACCUM_SATURATE_EN
    sum.re = sat_add(base.re, prod2.re, ovf_re);
    sum.im = sat_add(base.im, prod2.im, ovf_im);
`else
    sum = add_wrap(base, prod2);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      hit1_q      <= 1'b0;
      g1_q        <= '0;
      g2_q        <= '0;
      clr_cnt_q   <= '0;
      d1_q        <= '0;
      hold1_q     <= '0;
      base2_q     <= '0;
      grid_we     <= 1'b0;
      grid_waddr  <= '0;
      grid_wdatar <= '0;
      grid_wdatai <= '0;
      drop_err    <= 1'b0;
`ifdef GRID_ACCUM_SATURATE_EN
      sat_flag    <= 1'b0;
`endif
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;

      if (accept) begin
        g1_q    <= gind;
        d1_q    <= '{re: indatar, im: indatai};
        hit1_q  <= grid_we && (grid_waddr == gind);
        hold1_q <= wdat;
      end

      if (v1_q) begin
        g2_q    <= g1_q;
        base2_q <= base1;
      end

      if (v2_q) begin
        grid_we     <= 1'b1;
        grid_waddr  <= g2_q;
        grid_wdatar <= sum.re;
        grid_wdatai <= sum.im;
      end else if (clr_go) begin
        grid_we     <= 1'b1;
        grid_waddr  <= clr_cnt_q;
        grid_wdatar <= '0;
        grid_wdatai <= '0;
      end else begin
        grid_we <= 1'b0;
      end

      if (valid && (state_q == StClear)) begin
        drop_err <= 1'b1;
      end
`ifdef GRID_ACCUM_SATURATE_EN
      if (v2_q && (ovf_re || ovf_im)) begin
        sat_flag <= 1'b1;
      end
`endif

      unique case (state_q)
        StIdle: begin
          if (clear) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end else if (valid) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (clear) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end else if (!valid && !v1_q && !v2_q) begin
            state_q <= StIdle;
          end
        end
        StClear: begin
          if (clear) begin
            clr_cnt_q <= '0;
          end else if (clr_go) begin
            if (clr_cnt_q == LastAddr) begin
              state_q <= StIdle;
            end
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/grid_accum.md
Name: grid_accum

Overview:
- Gridding back-end stage, directly downstream of the convolution-index generator.
- Per valid cycle: takes a grid index (gind), kernel index (cind) and complex visibility, reads kernel coefficient and current grid cell, complex-multiplies, adds, writes back.
- Read-modify-write pipeline with in-flight forwarding.
- Also owns grid clearing before each gridding pass.

Parameters:
- PRECISION, 32, signed width of each real/imag component (data, kernel, grid).
- KFRAC, 30, fractional bits of kernel coefficients; product is arithmetically shifted right by KFRAC.
- GSIZE, 32, grid side; the grid holds GSIZE*GSIZE cells.
- ADDR_W, 16, width of gind, cind and memory addresses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid  in  1  upstream sample valid; no backpressure exists.
- gind  in  ADDR_W  grid cell index.
- cind  in  ADDR_W  kernel coefficient index.
- indatar / indatai  in  PRECISION each  visibility real/imag.
- clear  in  1  one-cycle pulse: start zeroing the grid.
- busy  out  1  clear in progress or pipeline non-empty.
- drop_err  out  1  sticky: valid arrived during CLEAR.
- conv_addr  out  ADDR_W  kernel memory read address (1-cycle latency).
- conv_datar / conv_datai  in  PRECISION each  kernel coefficient.
- grid_raddr  out  ADDR_W  grid memory read address (1-cycle latency, read-first).
- grid_rdatar / grid_rdatai  in  PRECISION each  grid read data.
- grid_we  out  1  grid write enable.
- grid_waddr  out  ADDR_W  grid write address.
- grid_wdatar / grid_wdatai  out  PRECISION each  grid write data.

Behaviour:
- Reset (rst=0, async): state IDLE, all pipeline valids 0, grid_we=0, busy=0, drop_err=0, all address/data outputs 0.
- FSM states:
  - IDLE -> RUN on first valid.
  - IDLE or RUN -> CLEAR on clear.
  - CLEAR -> IDLE after address GSIZE*GSIZE-1 is written.
  - RUN -> IDLE when the pipeline has drained and valid=0.
- Stage 0 (input edge k): conv_addr=cind and grid_raddr=gind driven combinationally from inputs; data, gind and valid registered.
- Stage 1 (edge k+1): memory data returned; product pr=(dr*kr-di*ki)>>>KFRAC, pi=(dr*ki+di*kr)>>>KFRAC. Full-width intermediates, truncated to PRECISION.
- Stage 2 (edge k+2): sum = base + product. base = grid_rdata captured at stage 1, unless forwarding applies.
- Forwarding: if any of the up to 3 younger in-flight writes has an equal address, base = the youngest such sum. Priority: stage-3 write > stage-2 sum > value registered at stage-1 capture.
- Write: grid_we=1 in the cycle after edge k+2, with grid_waddr=gind and wdata=sum. Fixed latency of 3 edges; back-to-back throughput 1/cycle.
- Consecutive identical gind on every cycle must accumulate exactly, without loss.
- CLEAR: one cell per cycle, grid_we=1, waddr=0..GSIZE*GSIZE-1, wdata=0.
  - A valid arriving in CLEAR is discarded and sets drop_err.
  - clear pulsed during CLEAR restarts the counter at 0.
  - clear in RUN: in-flight writes complete first, then zeroing begins. No interleaving on the write port.
- Addition wraps modulo 2^PRECISION (see option).
- busy=1 in CLEAR or while any pipeline stage holds valid.

Optional Feature:
- Macro GRID_ACCUM_SATURATE_EN.
- Defined: stage-2 add saturates to +(2^(P-1)-1) / -(2^(P-1)) per component, and a sticky output sat_flag (1 bit, reset 0) is added.
- Undefined: wrapping add, no sat_flag port.

Decomposition:
- Shared package gridding_pkg: PRECISION, KFRAC, GSIZE, ADDR_W, the complex-sample struct type (re/im), and the state enum.
- One sub-module, cmul_q: registered complex multiplier with the KFRAC shift (stage 1).

Test Plan:
- Single sample: kernel[5]=(2^30,0) i.e. 1.0, grid[100]=(10,-3); valid, gind=100, cind=5, data=(7,4) -> grid_we 3 cycles later, waddr=100, wdata=(17,1).
- Same gind on 4 consecutive cycles with data=(1,0) and kernel=1.0, grid[7]=0 -> final write (4,0), intermediate writes 1,2,3 (exercises forwarding).
- Kernel=(0,2^30) i.e. j, data=(3,5), grid=0 -> wdata=(-5,3).
- clear pulse with GSIZE=32 -> 1024 writes of 0 to addresses 0..1023, busy high throughout; valid injected at cycle 10 -> drop_err=1, no extra write.
- rst asserted mid-pipeline with 2 samples in flight -> grid_we drops immediately, no write after release, busy=0.
- With GRID_ACCUM_SATURATE_EN: grid=(2^31-2,0), product (5,0) -> wdata=(2^31-1,0), sat_flag=1. Without the macro -> wdata=(-2^31+3,0).
